// File: rtl/gfx_fixed_pkg.sv
// Shared signed fixed-point types and helpers for the geometry pipeline.
// All matrix elements and coordinates are Q(FX_WIDTH-FX_FRAC).FX_FRAC words.
package gfx_fixed_pkg;

   localparam int unsigned FX_WIDTH  = 32;
   localparam int unsigned FX_FRAC   = 16;
   localparam int unsigned ACC_WIDTH = 2 * FX_WIDTH + 2;

   typedef logic signed [FX_WIDTH-1:0]  fx_t;
   typedef fx_t [3:0][3:0]              mat4_t;
   typedef logic signed [ACC_WIDTH-1:0] acc_t;

   typedef enum logic [1:0] {StIdle, StMac, StOut} vvt_state_e;

   localparam fx_t FX_ZERO = '0;
   localparam fx_t FX_ONE  = {{(FX_WIDTH-FX_FRAC-1){1'b0}}, 1'b1, {FX_FRAC{1'b0}}};
   localparam fx_t FX_MAX  = {1'b0, {(FX_WIDTH-1){1'b1}}};
   localparam fx_t FX_MIN  = {1'b1, {(FX_WIDTH-1){1'b0}}};

   // Row 3 is the most significant slice of the packed matrix.
   localparam mat4_t MAT4_IDENTITY = {{FX_ONE,  FX_ZERO, FX_ZERO, FX_ZERO},
                                      {FX_ZERO, FX_ONE,  FX_ZERO, FX_ZERO},
                                      {FX_ZERO, FX_ZERO, FX_ONE,  FX_ZERO},
                                      {FX_ZERO, FX_ZERO, FX_ZERO, FX_ONE}};

   // Drop the fraction (floor) and clamp into the representable range.
   function automatic fx_t fx_sat(input acc_t acc);
      acc_t shifted;
      shifted = acc >>> FX_FRAC;
      if (shifted > acc_t'(FX_MAX)) return FX_MAX;
      if (shifted < acc_t'(FX_MIN)) return FX_MIN;
      return fx_t'(shifted);
   endfunction

endpackage

// File: rtl/dot4_fixed.sv
// Combinational 4-term signed fixed-point dot product with rescale and saturation.
module dot4_fixed import gfx_fixed_pkg::*; (
   input  logic [3:0][FX_WIDTH-1:0] row,
   input  logic [3:0][FX_WIDTH-1:0] vec,
   output logic [FX_WIDTH-1:0]      result
);

   acc_t acc;

   // Full-width products; the two guard bits absorb the four-way sum.
   always_comb begin
      acc = '0;
      for (int j = 0; j < 4; j++) begin
         acc = acc + acc_t'($signed(row[j])) * acc_t'($signed(vec[j]));
      end
      result = fx_sat(acc);
   end

endmodule

// File: rtl/vertex_view_transform.sv
// Applies the latched 4x4 view matrix to world-space vertices, one row per cycle.
// Matrix loads land in a shadow copy and are promoted only in an idle IDLE cycle.
module vertex_view_transform import gfx_fixed_pkg::*; #(
   parameter int unsigned WIDTH = FX_WIDTH,
   parameter int unsigned FRAC  = FX_FRAC
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         matrix_load,
   input  logic [3:0][3:0][WIDTH-1:0]   matrix_in,
   input  logic                         vtx_valid_in,
   output logic                         vtx_ready_out,
   input  logic [WIDTH-1:0]             x_in,
   input  logic [WIDTH-1:0]             y_in,
   input  logic [WIDTH-1:0]             z_in,
   output logic                         vtx_valid_out,
   input  logic                         vtx_ready_in,
   output logic [WIDTH-1:0]             x_out,
   output logic [WIDTH-1:0]             y_out,
   output logic [WIDTH-1:0]             z_out,
   output logic [WIDTH-1:0]             w_out,
   output logic                         busy
);

   localparam logic [WIDTH-1:0] VtxW = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

   vvt_state_e              state;
   logic [1:0]              row;
   logic [3:0][WIDTH-1:0]   vtx;
   logic [3:0][WIDTH-1:0]   res;
   mat4_t                   active;
   mat4_t                   shadow;
   logic                    pending;
   logic [FX_WIDTH-1:0]     dot_y;

   dot4_fixed u_dot4 (
      .row    (active[row]),
      .vec    (vtx),
      .result (dot_y)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state         <= StIdle;
         row           <= '0;
         vtx           <= '0;
         res           <= '0;
         active        <= MAT4_IDENTITY;
         shadow        <= MAT4_IDENTITY;
         pending       <= 1'b0;
         vtx_valid_out <= 1'b0;
         vtx_ready_out <= 1'b1;
         busy          <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (vtx_valid_in) begin
                  vtx           <= {VtxW, z_in, y_in, x_in};
                  row           <= '0;
                  state         <= StMac;
                  vtx_ready_out <= 1'b0;
                  busy          <= 1'b1;
               end else if (pending) begin
                  active  <= shadow;
                  pending <= 1'b0;
               end
            end
            StMac: begin
               res[row] <= dot_y;
               row      <= row + 2'd1;
               if (row == 2'd3) begin
                  state         <= StOut;
                  vtx_valid_out <= 1'b1;
               end
            end
            StOut: begin
               if (vtx_ready_in) begin
                  state         <= StIdle;
                  vtx_valid_out <= 1'b0;
                  vtx_ready_out <= 1'b1;
                  busy          <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
         // Placed after the promotion so a same-cycle load stays pending.
         if (matrix_load) begin
            shadow  <= matrix_in;
            pending <= 1'b1;
         end
      end
   end

   assign x_out = res[0];
   assign y_out = res[1];
   assign z_out = res[2];
   assign w_out = res[3];

endmodule

// File: tb/tb_vertex_view_transform.sv
// Scoreboard bench for vertex_view_transform: a matrix/buffer model predicts each result.
module tb_vertex_view_transform;

   localparam logic [31:0] ONE = 32'h0001_0000;

   typedef logic [3:0][3:0][31:0] mat_t;
   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      logic [31:0] w;
   } vec_t;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        matrix_load;
   mat_t        matrix_in;
   logic        vtx_valid_in;
   logic        vtx_ready_out;
   logic [31:0] x_in, y_in, z_in;
   logic        vtx_valid_out;
   logic        vtx_ready_in;
   logic [31:0] x_out, y_out, z_out, w_out;
   logic        busy;

   int   n_checks;
   int   n_fail;
   int   cyc = 0;
   mat_t m_active, m_shadow;
   bit   m_pending;
   vec_t exp_q[$];
   vec_t mon_exp;

   vertex_view_transform dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .matrix_load   (matrix_load),
      .matrix_in     (matrix_in),
      .vtx_valid_in  (vtx_valid_in),
      .vtx_ready_out (vtx_ready_out),
      .x_in          (x_in),
      .y_in          (y_in),
      .z_in          (z_in),
      .vtx_valid_out (vtx_valid_out),
      .vtx_ready_in  (vtx_ready_in),
      .x_out         (x_out),
      .y_out         (y_out),
      .z_out         (z_out),
      .w_out         (w_out),
      .busy          (busy)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic mat_t ident();
      mat_t m;
      m = '0;
      for (int i = 0; i < 4; i++) m[i][i] = ONE;
      return m;
   endfunction

   function automatic logic [31:0] rnd_fx();
      return $urandom_range(0, 32'h7FFFF) - 32'h40000;
   endfunction

   function automatic logic [31:0] model_row(input mat_t m, input int r,
                                             input logic [3:0][31:0] v);
      logic signed [65:0] acc, a, b;
      acc = '0;
      for (int j = 0; j < 4; j++) begin
         a = $signed(m[r][j]);
         b = $signed(v[j]);
         acc = acc + a * b;
      end
      acc = acc >>> 16;
      if (acc > 66'sd2147483647) return 32'h7FFF_FFFF;
      if (acc < -66'sd2147483648) return 32'h8000_0000;
      return acc[31:0];
   endfunction

   function automatic vec_t model_vec(input mat_t m, input logic [31:0] x, y, z);
      logic [3:0][31:0] v;
      vec_t r;
      v = {ONE, z, y, x};
      r.x = model_row(m, 0, v);
      r.y = model_row(m, 1, v);
      r.z = model_row(m, 2, v);
      r.w = model_row(m, 3, v);
      return r;
   endfunction

   // Reference for the double buffer; handshakes are judged on pre-edge values.
   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         m_active  <= ident();
         m_shadow  <= ident();
         m_pending <= 1'b0;
         exp_q.delete();
      end else begin
         if (vtx_ready_out && vtx_valid_in) begin
            exp_q.push_back(model_vec(m_active, x_in, y_in, z_in));
         end else if (vtx_ready_out && m_pending) begin
            m_active  <= m_shadow;
            m_pending <= 1'b0;
         end
         if (matrix_load) begin
            m_shadow  <= matrix_in;
            m_pending <= 1'b1;
         end
      end
   end

   always @(negedge clk_in) begin
      if (rst_in === 1'b0 && vtx_valid_out && vtx_ready_in) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_extra: got %h %h %h %h with nothing expected",
                     x_out, y_out, z_out, w_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({x_out, y_out, z_out, w_out} !== mon_exp) begin
               n_fail++;
               $display("FAIL scoreboard: got %h %h %h %h, required %h %h %h %h",
                        x_out, y_out, z_out, w_out, mon_exp.x, mon_exp.y, mon_exp.z, mon_exp.w);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, %0d checks %0d failures", n_checks, n_fail);
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic load_mat(input mat_t m);
      matrix_in   = m;
      matrix_load = 1'b1;
      tick(1);
      matrix_load = 1'b0;
   endtask

   task automatic send_vertex(input logic [31:0] x, y, z, output int acc_cyc);
      bit accepted;
      accepted = 1'b0;
      acc_cyc  = -1;
      x_in = x; y_in = y; z_in = z;
      vtx_valid_in = 1'b1;
      for (int t = 0; t < 50 && !accepted; t++) begin
         @(posedge clk_in);
         accepted = vtx_ready_out;
         acc_cyc  = cyc;
         #1;
      end
      vtx_valid_in = 1'b0;
      if (!accepted) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: vtx_ready_out=%b after 50 cycles, required 1", vtx_ready_out);
      end
   endtask

   task automatic wait_valid(input string name);
      int t;
      t = 0;
      @(negedge clk_in);
      while (!vtx_valid_out && t < 40) begin
         @(negedge clk_in);
         t++;
      end
      n_checks++;
      if (vtx_valid_out !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timeout: vtx_valid_out=%b, required 1", name, vtx_valid_out);
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk_in);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      #2;
      n_checks++;
      if (vtx_ready_out !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b, required 1", vtx_ready_out);
      end
      n_checks++;
      if (vtx_valid_out !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b, required 0", vtx_valid_out);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b, required 0", busy);
      end
      n_checks++;
      if ({x_out, y_out, z_out, w_out} !== 128'd0) begin
         n_fail++; $display("FAIL reset_data: got %h %h %h %h, required 0", x_out, y_out, z_out, w_out);
      end
      tick(2);
      rst_in = 1'b0;
      tick(1);
   endtask

   task automatic test_identity();
      vtx_ready_in = 1'b1;
      x_in = 32'h0002_0000; y_in = 32'hFFFD_0000; z_in = 32'h0000_8000;
      vtx_valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      vtx_valid_in = 1'b0;
      @(negedge clk_in);
      n_checks++;
      if (vtx_ready_out !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mac_flags: ready_out=%b busy=%b, required 0 1", vtx_ready_out, busy);
      end
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      n_checks++;
      if (vtx_valid_out !== 1'b0) begin
         n_fail++; $display("FAIL latency_early: valid_out=%b at +4, required 0", vtx_valid_out);
      end
      @(negedge clk_in);
      n_checks++;
      if (vtx_valid_out !== 1'b1) begin
         n_fail++; $display("FAIL latency: valid_out=%b at +5, required 1", vtx_valid_out);
      end
      n_checks++;
      if ({x_out, y_out, z_out, w_out} !== {32'h0002_0000, 32'hFFFD_0000, 32'h0000_8000, ONE}) begin
         n_fail++;
         $display("FAIL identity: got %h %h %h %h, required 00020000 fffd0000 00008000 00010000",
                  x_out, y_out, z_out, w_out);
      end
      drain();
   endtask

   task automatic test_translation();
      mat_t m;
      int   c;
      m = ident();
      m[0][3] = 32'h0001_0000; m[1][3] = 32'h0002_0000; m[2][3] = 32'h0003_0000;
      load_mat(m);
      tick(1);
      send_vertex(ONE, ONE, ONE, c);
      wait_valid("translation");
      n_checks++;
      if ({x_out, y_out, z_out, w_out} !== {32'h0002_0000, 32'h0003_0000, 32'h0004_0000, ONE}) begin
         n_fail++;
         $display("FAIL translation: got %h %h %h %h, required 2.0 3.0 4.0 1.0",
                  x_out, y_out, z_out, w_out);
      end
      drain();
   endtask

   task automatic test_rotation();
      mat_t m;
      int   c;
      m = ident();
      m[1][1] = '0; m[2][2] = '0;
      m[1][2] = 32'h0001_0000; m[2][1] = 32'hFFFF_0000;
      load_mat(m);
      tick(1);
      send_vertex(32'h0, ONE, 32'h0, c);
      wait_valid("rotation");
      n_checks++;
      if ({x_out, y_out, z_out, w_out} !== {32'h0, 32'h0, 32'hFFFF_0000, ONE}) begin
         n_fail++;
         $display("FAIL rotation: got %h %h %h %h, required 0 0 ffff0000 00010000",
                  x_out, y_out, z_out, w_out);
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [127:0] held;
      int           c;
      vtx_ready_in = 1'b0;
      send_vertex(32'h0001_8000, 32'hFFFE_4000, 32'h0000_0123, c);
      wait_valid("backpressure");
      held = {x_out, y_out, z_out, w_out};
      x_in = rnd_fx(); y_in = rnd_fx(); z_in = rnd_fx();
      vtx_valid_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_in);
         n_checks++;
         if ({x_out, y_out, z_out, w_out} !== held || vtx_valid_out !== 1'b1 ||
             vtx_ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_%0d: data=%h valid=%b ready=%b, required data=%h valid=1 ready=0",
                     i, {x_out, y_out, z_out, w_out}, vtx_valid_out, vtx_ready_out, held);
         end
      end
      @(posedge clk_in);
      #1;
      vtx_valid_in = 1'b0;
      vtx_ready_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      n_checks++;
      if (vtx_ready_out !== 1'b1 || vtx_valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL release: ready_out=%b valid_out=%b, required 1 0", vtx_ready_out, vtx_valid_out);
      end
      drain();
   endtask

   task automatic test_load_during_mac();
      mat_t mt, mg;
      int   c;
      mt = ident();
      mt[0][3] = 32'h0001_0000; mt[1][3] = 32'h0002_0000; mt[2][3] = 32'h0003_0000;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) mg[i][j] = rnd_fx();
      send_vertex(ONE, 32'h0002_0000, 32'h0003_0000, c);
      load_mat(mg);
      load_mat(mt);
      wait_valid("old_matrix");
      n_checks++;
      if ({x_out, y_out, z_out, w_out} !== {ONE, 32'h0003_0000, 32'hFFFE_0000, ONE}) begin
         n_fail++;
         $display("FAIL old_matrix: got %h %h %h %h, required 1.0 3.0 -2.0 1.0",
                  x_out, y_out, z_out, w_out);
      end
      drain();
      tick(1);
      send_vertex(ONE, 32'h0002_0000, 32'h0003_0000, c);
      wait_valid("new_matrix");
      n_checks++;
      if ({x_out, y_out, z_out, w_out} !== {32'h0002_0000, 32'h0004_0000, 32'h0006_0000, ONE}) begin
         n_fail++;
         $display("FAIL new_matrix: got %h %h %h %h, required 2.0 4.0 6.0 1.0",
                  x_out, y_out, z_out, w_out);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      mat_t mb;
      int   c_prev, c_now;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) mb[i][j] = rnd_fx();
      vtx_ready_in = 1'b1;
      // Load coincides with the first accept, so it must wait for a free IDLE cycle.
      matrix_in   = mb;
      matrix_load = 1'b1;
      send_vertex(rnd_fx(), rnd_fx(), rnd_fx(), c_prev);
      matrix_load = 1'b0;
      for (int k = 0; k < 3; k++) begin
         send_vertex(rnd_fx(), rnd_fx(), rnd_fx(), c_now);
         n_checks++;
         if (c_now - c_prev != 6) begin
            n_fail++;
            $display("FAIL throughput_%0d: accept spacing %0d cycles, required 6", k, c_now - c_prev);
         end
         c_prev = c_now;
      end
      drain();
      tick(1);
      send_vertex(rnd_fx(), rnd_fx(), rnd_fx(), c_now);
      drain();
   endtask

   task automatic test_saturation();
      mat_t ms;
      int   c;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) ms[i][j] = 32'h7FFF_FFFF;
      load_mat(ms);
      tick(1);
      send_vertex(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, c);
      wait_valid("sat_pos");
      n_checks++;
      if ({x_out, y_out, z_out, w_out} !== {4{32'h7FFF_FFFF}}) begin
         n_fail++;
         $display("FAIL sat_pos: got %h %h %h %h, required 7fffffff x4", x_out, y_out, z_out, w_out);
      end
      drain();
      send_vertex(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, c);
      wait_valid("sat_neg");
      n_checks++;
      if ({x_out, y_out, z_out, w_out} !== {4{32'h8000_0000}}) begin
         n_fail++;
         $display("FAIL sat_neg: got %h %h %h %h, required 80000000 x4", x_out, y_out, z_out, w_out);
      end
      drain();
   endtask

   task automatic test_reset_mid_mac();
      mat_t mg;
      int   c;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) mg[i][j] = rnd_fx();
      send_vertex(ONE, ONE, ONE, c);
      load_mat(mg);
      tick(1);
      rst_in = 1'b1;
      #2;
      n_checks++;
      if (vtx_valid_out !== 1'b0 || vtx_ready_out !== 1'b1 || busy !== 1'b0 ||
          {x_out, y_out, z_out, w_out} !== 128'd0) begin
         n_fail++;
         $display("FAIL mid_reset: valid=%b ready=%b busy=%b data=%h, required 0 1 0 0",
                  vtx_valid_out, vtx_ready_out, busy, {x_out, y_out, z_out, w_out});
      end
      tick(1);
      rst_in = 1'b0;
      tick(2);
      send_vertex(ONE, 32'h0002_0000, 32'h0003_0000, c);
      wait_valid("post_reset");
      n_checks++;
      if ({x_out, y_out, z_out, w_out} !== {ONE, 32'h0002_0000, 32'h0003_0000, ONE}) begin
         n_fail++;
         $display("FAIL post_reset_identity: got %h %h %h %h, required 1.0 2.0 3.0 1.0",
                  x_out, y_out, z_out, w_out);
      end
      drain();
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      matrix_load  = 1'b0;
      matrix_in    = '0;
      vtx_valid_in = 1'b0;
      vtx_ready_in = 1'b1;
      x_in = '0; y_in = '0; z_in = '0;
      test_reset();
      test_identity();
      test_translation();
      test_rotation();
      test_backpressure();
      test_load_during_mac();
      test_back_to_back();
      test_saturation();
      test_reset_mid_mac();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
